vid_pattern_gen: RTL and testbench

VID_PATTERN_GEN -- requirements
Module: vid_pattern_gen

---
 rtl/vid_pattern_gen_if.sv | 11 +
 rtl/vid_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_vid_pattern_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/vid_pattern_gen_if.sv
// vid_pattern_gen_if: Avalon-ST video stream bundle (24-bit beats, sop/eop, ready latency 0)
// Ports: data[23:0], valid, sop, eop (source -> sink); ready (sink -> source)
interface vid_pattern_gen_if;
    logic [23:0] data;
    logic        valid;
    logic        sop;
    logic        eop;
    logic        ready;
    modport master (output data, valid, sop, eop, input ready);
    modport slave (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: Avalon-ST video test pattern source (solid, bars, checkerboard, moving gradient)
// Ports: clk_65 pixel clock, reset async active-high, enable run request, pattern_sel/solid_rgb
// pattern controls, dout stream master, frame_count completed packets, busy FSM not idle.
// Macro VID_PATTERN_CTRL_PKT_EN adds a control packet (width/height/progressive) before each frame.
module vid_pattern_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768
) (
    input  logic              clk_65,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        pattern_sel,
    input  logic [23:0]       solid_rgb,
    vid_pattern_gen_if.master dout,
    output logic [15:0]       frame_count,
    output logic              busy
);
    localparam logic [11:0] X_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST = 12'(V_ACTIVE - 1);
    localparam logic [8:0] BAR_LAST = 9'(H_ACTIVE / 8 - 1);

`ifdef VID_PATTERN_CTRL_PKT_EN
    typedef enum logic [2:0] {IDLE, CTRL_HDR, CTRL_DATA, VID_HDR, PIXELS} state_t;
    localparam state_t FIRST = CTRL_HDR;
    localparam logic [23:0] FIRST_HDR = 24'h00000F;
    localparam logic [15:0] W = 16'(H_ACTIVE);
    localparam logic [15:0] HH = 16'(V_ACTIVE);
    // one nibble per symbol, symbol 0 in the low byte
    function automatic logic [23:0] ctrl_beat(input logic [1:0] b);
        return b == 2'd0 ? {4'h0, W[7:4], 4'h0, W[11:8], 4'h0, W[15:12]} :
               b == 2'd1 ? {4'h0, HH[11:8], 4'h0, HH[15:12], 4'h0, W[3:0]} :
                           {8'h03, 4'h0, HH[3:0], 4'h0, HH[7:4]};
    endfunction
`else
    typedef enum logic [1:0] {IDLE, VID_HDR, PIXELS} state_t;
    localparam state_t FIRST = VID_HDR;
    localparam logic [23:0] FIRST_HDR = 24'h000000;
`endif

    function automatic logic [23:0] pix(input logic [1:0] sel, input logic [23:0] rgb,
                                        input logic [7:0] grad, input logic chk, input logic [2:0] bar);
        return sel == 2'd0 ? rgb :
               sel == 2'd1 ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} :
               sel == 2'd2 ? (chk ? 24'h000000 : 24'hFFFFFF) : {3{grad}};
    endfunction

    state_t      state_q;
    logic [23:0] data_q;
    logic        valid_q;
    logic        sop_q;
    logic        eop_q;
    logic [15:0] frame_count_q;
    logic [11:0] x_q, y_q, x_d, y_d;
    logic [8:0]  bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_q, bar_d;
    logic [1:0]  sel_q;
    logic [23:0] rgb_q;
    logic        xfer, launch, last_x, bar_wrap;

    always_comb begin
        xfer = valid_q && dout.ready;
        // back-to-back: the next header is loaded on the same edge the EOP leaves
        launch = enable && (state_q == IDLE || (state_q == PIXELS && xfer && eop_q));
        last_x = x_q == X_LAST;
        bar_wrap = bar_cnt_q == BAR_LAST;
        x_d = last_x ? 12'd0 : x_q + 12'd1;
        y_d = last_x ? y_q + 12'd1 : y_q;
        bar_cnt_d = (last_x || bar_wrap) ? 9'd0 : bar_cnt_q + 9'd1;
        bar_d = last_x ? 3'd0 : bar_wrap ? bar_q + 3'd1 : bar_q;
    end

    always_ff @(posedge clk_65 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q <= '0;
            valid_q <= 1'b0;
            sop_q <= 1'b0;
            eop_q <= 1'b0;
            frame_count_q <= '0;
            x_q <= '0;
            y_q <= '0;
            bar_cnt_q <= '0;
            bar_q <= '0;
            sel_q <= '0;
            rgb_q <= '0;
        end else begin
            if (xfer && eop_q && state_q == PIXELS)
                frame_count_q <= frame_count_q + 16'd1;
            if (launch) begin
                state_q <= FIRST;
                valid_q <= 1'b1;
                sop_q <= 1'b1;
                eop_q <= 1'b0;
                data_q <= FIRST_HDR;
            end else if (xfer) begin
                case (state_q)
`ifdef VID_PATTERN_CTRL_PKT_EN
                    CTRL_HDR: begin
                        state_q <= CTRL_DATA;
                        x_q <= '0;
                        data_q <= ctrl_beat(2'd0);
                        sop_q <= 1'b0;
                    end
                    // x_q counts control beats 0..2; eop rides on beat 2
                    CTRL_DATA: begin
                        x_q <= x_q + 12'd1;
                        state_q <= x_q[1] ? VID_HDR : CTRL_DATA;
                        data_q <= x_q[1] ? 24'h000000 : ctrl_beat(x_q[1:0] + 2'd1);
                        sop_q <= x_q[1];
                        eop_q <= x_q[0];
                    end
`endif
                    VID_HDR: begin
                        state_q <= PIXELS;
                        sel_q <= pattern_sel;
                        rgb_q <= solid_rgb;
                        x_q <= '0;
                        y_q <= '0;
                        bar_cnt_q <= '0;
                        bar_q <= '0;
                        data_q <= pix(pattern_sel, solid_rgb, frame_count_q[7:0], 1'b0, 3'd0);
                        sop_q <= 1'b0;
                        eop_q <= 1'b0;
                    end
                    PIXELS: begin
                        if (eop_q) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            sop_q <= 1'b0;
                            eop_q <= 1'b0;
                        end else begin
                            x_q <= x_d;
                            y_q <= y_d;
                            bar_cnt_q <= bar_cnt_d;
                            bar_q <= bar_d;
                            data_q <= pix(sel_q, rgb_q, x_d[7:0] + frame_count_q[7:0], x_d[5] ^ y_d[5], bar_d);
                            eop_q <= x_d == X_LAST && y_d == Y_LAST;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dout.data = data_q;
    assign dout.valid = valid_q;
    assign dout.sop = sop_q;
    assign dout.eop = eop_q;
    assign frame_count = frame_count_q;
    assign busy = state_q != IDLE;
endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb_vid_pattern_gen: randomized self-checking bench for vid_pattern_gen against a packet-level model
module tb_vid_pattern_gen;
    localparam int H = 128;
    localparam int V = 36;
    localparam int NPIX = H * V;
    localparam int IDLE_PH = 6;
    localparam int LIMIT = 20000;
`ifdef VID_PATTERN_CTRL_PKT_EN
    localparam int START = 0;
`else
    localparam int START = 4;
`endif

    logic        clk_65 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h123456;
    logic [15:0] frame_count;
    logic        busy;
    logic        rand_ready = 1'b0;

    vid_pattern_gen_if dout();

    vid_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_65(clk_65),
        .reset(reset),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb),
        .dout(dout),
        .frame_count(frame_count),
        .busy(busy)
    );

    always #5 clk_65 = ~clk_65;

    always @(posedge clk_65) begin
        #1;
        dout.ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] ctrl_exp(input int k);
        logic [15:0] w;
        logic [15:0] h;
        logic [3:0] nib [9];
        w = 16'(H);
        h = 16'(V);
        nib = '{w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], 4'h3};
        return {4'h0, nib[3*k+2], 4'h0, nib[3*k+1], 4'h0, nib[3*k]};
    endfunction

    function automatic logic [23:0] exp_pix(input int n, input logic [1:0] s, input logic [23:0] c, input int f);
        int x, y, bar;
        logic [7:0] g;
        x = n % H;
        y = n / H;
        bar = x / (H / 8);
        g = 8'((x + f) % 256);
        case (s)
            2'd0: return c;
            2'd1: return {(bar & 2) != 0 ? 8'h00 : 8'hFF, (bar & 4) != 0 ? 8'h00 : 8'hFF, (bar & 1) != 0 ? 8'h00 : 8'hFF};
            2'd2: return (((x / 32) + (y / 32)) % 2) != 0 ? 24'h000000 : 24'hFFFFFF;
            default: return {g, g, g};
        endcase
    endfunction

    // model: ph 0 ctrl hdr, 1..3 ctrl data, 4 video hdr, 5 pixels, 6 idle
    int          m_ph = IDLE_PH;
    int          m_n = 0;
    int          m_fc = 0;
    logic [1:0]  m_sel = 2'd0;
    logic [23:0] m_rgb = 24'h0;
    logic        hold = 1'b0, exp_on = 1'b0, exp_off = 1'b0;
    logic [23:0] h_data, e_data;
    logic        h_sop, h_eop, e_sop, e_eop;

    always @(negedge clk_65) begin
        if (reset) begin
            m_ph = IDLE_PH;
            m_fc = 0;
            hold = 1'b0;
            exp_on = 1'b0;
            exp_off = 1'b0;
        end else begin
            check("frame_count", frame_count, 32'(16'(m_fc)));
            if (exp_on) check("gap_valid", dout.valid, 1);
            if (exp_off) begin
                check("idle_valid", dout.valid, 0);
                check("idle_busy", busy, 0);
            end
            exp_on = 1'b0;
            exp_off = 1'b0;
            if (hold) begin
                check("hold_valid", dout.valid, 1);
                check("hold_data", dout.data, h_data);
                check("hold_sop", dout.sop, h_sop);
                check("hold_eop", dout.eop, h_eop);
            end
            hold = 1'b0;
            if (m_ph == IDLE_PH) begin
                check("idle_no_valid", dout.valid, 0);
                if (enable) begin
                    m_ph = START;
                    exp_on = 1'b1;
                end
            end else if (dout.valid) begin
                e_sop = m_ph == 0 || m_ph == 4;
                e_eop = m_ph == 3 || (m_ph == 5 && m_n == NPIX - 1);
                e_data = m_ph == 0 ? 24'h00000F : m_ph < 4 ? ctrl_exp(m_ph - 1) :
                         m_ph == 4 ? 24'h000000 : exp_pix(m_n, m_sel, m_rgb, m_fc);
                check($sformatf("data_ph%0d_n%0d", m_ph, m_n), dout.data, e_data);
                check("sop", dout.sop, e_sop);
                check("eop", dout.eop, e_eop);
                check("busy_active", busy, 1);
                hold = !dout.ready;
                h_data = dout.data;
                h_sop = dout.sop;
                h_eop = dout.eop;
                if (dout.ready) begin
                    if (m_ph < 4) m_ph++;
                    else if (m_ph == 4) begin
                        m_ph = 5;
                        m_n = 0;
                        m_sel = pattern_sel;
                        m_rgb = solid_rgb;
                    end else if (m_n == NPIX - 1) begin
                        m_fc++;
                        m_ph = enable ? START : IDLE_PH;
                        exp_on = enable;
                        exp_off = !enable;
                    end else m_n++;
                end
            end
        end
    end

    task automatic wait_pix(input int f, input int k);
        int i = 0;
        while (!(m_fc == f && m_ph == 5 && m_n >= k) && i < LIMIT) begin
            @(posedge clk_65);
            i++;
        end
        #1;
        check($sformatf("wait_pix_f%0d_timeout", f), i < LIMIT, 1);
    endtask

    task automatic wait_idle();
        int i = 0;
        while (!(m_ph == IDLE_PH && !busy) && i < LIMIT) begin
            @(posedge clk_65);
            i++;
        end
        #1;
        check("wait_idle_timeout", i < LIMIT, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk_65);
        #1;
        check("rst_valid", dout.valid, 0);
        check("rst_sop", dout.sop, 0);
        check("rst_eop", dout.eop, 0);
        check("rst_data", dout.data, 0);
        check("rst_fc", frame_count, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (4) @(posedge clk_65);
        #1;
        check("pre_busy", busy, 0);
        check("pre_valid", dout.valid, 0);
        enable = 1'b1;
        wait_pix(0, 10);
        enable = 1'b0;
        wait_idle();
        check("fc_first", frame_count, 1);
        repeat (20) @(posedge clk_65);
        #1;
        check("no_hdr_valid", dout.valid, 0);
        check("no_hdr_busy", busy, 0);
        pattern_sel = 2'd1;
        enable = 1'b1;
        wait_pix(1, 100);
        pattern_sel = 2'd2;
        solid_rgb = 24'($urandom);
        wait_pix(2, 100);
        pattern_sel = 2'd3;
        rand_ready = 1'b1;
        for (int f = 3; f < 6; f++) begin
            wait_pix(f, int'($urandom_range(1, NPIX - 2)));
            pattern_sel = 2'($urandom);
            solid_rgb = 24'($urandom);
        end
        rand_ready = 1'b0;
        wait_pix(6, 50);
        reset = 1'b1;
        #1;
        check("arst_valid", dout.valid, 0);
        check("arst_sop", dout.sop, 0);
        check("arst_eop", dout.eop, 0);
        check("arst_data", dout.data, 0);
        check("arst_fc", frame_count, 0);
        check("arst_busy", busy, 0);
        repeat (2) @(posedge clk_65);
        #1;
        reset = 1'b0;
        wait_pix(0, 20);
        enable = 1'b0;
        wait_idle();
        check("fc_after_reset", frame_count, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
